// File: rtl/pc_return_stack.sv
// pc_return_stack
// Program-counter unit with a hardware return-address stack.
// The PC advances on every non-stalled cycle. Supported operations are
// sequential fetch, conditional relative branch, relative call, return and
// absolute jump. A call pushes its return address and a return pops it.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst    synchronous reset, active-high; has priority over stall and op
//   stall  holds all state and ignores op
//   op     000 NEXT, 001 BRC, 010 CALL, 011 RET, 100 JMP, 101-111 HOLD
//   flag   branch condition, used only by BRC
//   immd   relative offset (BRC/CALL) or absolute target (JMP)
//   pc     current PC, registered
//   sp     number of valid stack entries, 0..DEPTH
//   empty  sp == 0
//   full   sp == DEPTH
//   ovf    sticky: CALL issued while full
//   unf    sticky: RET issued while empty
module pc_return_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8,
    parameter int SP_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [2:0]      op,
    input  logic            flag,
    input  logic [PC_W-1:0] immd,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_BRC  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;

    logic [PC_W-1:0]  stack [DEPTH];

    logic [PC_W-1:0]  seq;
    logic [PC_W-1:0]  tgt;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    logic [PC_W-1:0]  pc_nxt;
    logic [SP_W-1:0]  sp_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             push;

    assign seq   = pc + PC_W'(1);
    assign tgt   = pc + immd + PC_W'(1);
    assign empty = (sp == '0);
    assign full  = (sp == SP_W'(DEPTH));

    // When full, sp's low bits alias entry 0, but no push happens then.
    assign push_idx = IDX_W'(sp);
    assign top_idx  = IDX_W'(sp - SP_W'(1));

    always_comb begin
        pc_nxt  = pc;
        sp_nxt  = sp;
        ovf_nxt = ovf;
        unf_nxt = unf;
        push    = 1'b0;
        if (!stall) begin
            case (op)
                OP_NEXT: pc_nxt = seq;
                OP_BRC:  pc_nxt = flag ? tgt : seq;
                OP_CALL: begin
                    if (full) begin
                        pc_nxt  = seq;
                        ovf_nxt = 1'b1;
                    end else begin
                        push   = 1'b1;
                        sp_nxt = sp + SP_W'(1);
                        pc_nxt = tgt;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        pc_nxt  = seq;
                        unf_nxt = 1'b1;
                    end else begin
                        // Popped entry is left in place; sp alone marks validity.
                        pc_nxt = stack[top_idx];
                        sp_nxt = sp - SP_W'(1);
                    end
                end
                OP_JMP:  pc_nxt = immd;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= '0;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            pc  <= pc_nxt;
            sp  <= sp_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
            if (push) begin
                stack[push_idx] <= seq;
            end
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;

    localparam int PC_W  = 12;
    localparam int DEPTH = 8;
    localparam int SP_W  = 4;
    localparam int MASK  = (1 << PC_W) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [2:0]      op;
    logic            flag;
    logic [PC_W-1:0] immd;
    logic [PC_W-1:0] pc;
    logic [SP_W-1:0] sp;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            unf;

    pc_return_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .SP_W(SP_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .op    (op),
        .flag  (flag),
        .immd  (immd),
        .pc    (pc),
        .sp    (sp),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .unf   (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int e_pc;
        int e_sp;
        bit e_empty;
        bit e_full;
        bit e_ovf;
        bit e_unf;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the stack is a plain queue, top at the back.
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    int n_pass  = 0;
    int n_total = 0;
    int n_step  = 0;
    bit done    = 0;

    function automatic void model(input bit r, input bit s, input int o,
                                  input bit f, input int im);
        int seq_v;
        int tgt_v;
        seq_v = (m_pc + 1) & MASK;
        tgt_v = (m_pc + im + 1) & MASK;
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (!s) begin
            case (o)
                0: m_pc = seq_v;
                1: m_pc = f ? tgt_v : seq_v;
                2: begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back(seq_v);
                        m_pc = tgt_v;
                    end else begin
                        m_pc = seq_v;
                        m_ovf = 1;
                    end
                end
                3: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_pc = seq_v;
                        m_unf = 1;
                    end
                end
                4: m_pc = im;
                default: ;
            endcase
        end
    endfunction

    task automatic step(input bit r, input bit s, input int o, input bit f, input int im);
        exp_t e;
        rst   = r;
        stall = s;
        op    = 3'(o);
        flag  = f;
        immd  = PC_W'(im);
        model(r, s, o, f, im & MASK);
        e.tag     = n_step;
        e.e_pc    = m_pc;
        e.e_sp    = m_stk.size();
        e.e_empty = (m_stk.size() == 0);
        e.e_full  = (m_stk.size() == DEPTH);
        e.e_ovf   = m_ovf;
        e.e_unf   = m_unf;
        exp_q.push_back(e);
        n_step++;
        @(negedge clk);
    endtask

    // Monitor: one registered result per edge, compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (int'(pc) == e.e_pc && int'(sp) == e.e_sp && empty == e.e_empty &&
                    full == e.e_full && ovf == e.e_ovf && unf == e.e_unf) begin
                    n_pass++;
                end else begin
                    $display("FAIL step%0d: got pc=%h sp=%0d empty=%0b full=%0b ovf=%0b unf=%0b, want pc=%h sp=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
                             e.tag, pc, sp, empty, full, ovf, unf,
                             e.e_pc, e.e_sp, e.e_empty, e.e_full, e.e_ovf, e.e_unf);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got done=%0b want 1", done);
        $fatal(1);
    end

    initial begin
        m_pc = 0;
        m_ovf = 0;
        m_unf = 0;

        // Reset then sequential fetch
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Branches including wrap
        step(0, 0, 4, 0, 'h010);
        step(0, 0, 1, 1, 'h005);
        step(0, 0, 1, 0, 'h005);
        step(0, 0, 4, 0, 'hFFE);
        step(0, 0, 1, 1, 'h001);

        // Nested calls
        step(0, 0, 4, 0, 'h020);
        step(0, 0, 2, 0, 'h0FF);
        step(0, 0, 2, 0, 'h00F);
        step(0, 0, 3, 0, 0);
        step(0, 0, 3, 0, 0);

        // Fill, overflow, call-to-self, then drain
        step(0, 0, 2, 0, 'hFFF);
        for (int i = 0; i < 7; i++) step(0, 0, 2, 0, $urandom_range(0, MASK));
        step(0, 0, 2, 0, 'h123);
        for (int i = 0; i < 9; i++) step(0, 0, 3, 0, 0);

        // Underflow and hold
        step(1, 0, 0, 0, 0);
        step(0, 0, 4, 0, 'h040);
        step(0, 0, 3, 0, 0);
        step(0, 0, 4, 0, 'hABC);
        step(0, 0, 7, 0, 'h555);
        step(0, 0, 5, 1, 'h001);
        step(0, 0, 6, 1, 'h002);

        // Stall and reset under stall
        for (int i = 0; i < 3; i++) step(0, 0, 2, 0, $urandom_range(0, MASK));
        for (int i = 0; i < 3; i++) step(0, 1, 2, 1, $urandom_range(0, MASK));
        step(1, 1, 2, 0, 'h010);
        step(0, 0, 3, 0, 0);

        // Randomized traffic, biased toward CALL/RET to exercise depth limits
        for (int i = 0; i < 2000; i++) begin
            int o;
            int pick;
            pick = int'($urandom_range(0, 15));
            if (pick < 5)       o = 2;
            else if (pick < 10) o = 3;
            else                o = int'($urandom_range(0, 7));
            step(($urandom_range(0, 127) == 0), ($urandom_range(0, 7) == 0),
                 o, 1'($urandom), int'($urandom_range(0, MASK)));
        end

        rst = 0;
        stall = 1;
        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());

        done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Sequential program-counter unit with a hardware return-address stack.
- Owns the architectural PC register and advances it every non-stalled cycle.
- Supports sequential fetch, conditional relative branch, relative call, return and absolute jump.
- The call/return path is the counterpart of the branch-target adder: a call pushes the return address, and a return pops it to restore the PC.

Parameters:
- PC_W, 12, width of PC, immediate and stack entries.
- DEPTH, 8, number of return-stack entries; must be a power of two and at least 2.
- SP_W, 4, stack-pointer width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  when 1, all state holds; op is ignored.
- op  input  3  command: 000 NEXT, 001 BRC, 010 CALL, 011 RET, 100 JMP, 101-111 HOLD.
- flag  input  1  branch condition, used only by BRC.
- immd  input  PC_W  relative offset (BRC/CALL) or absolute target (JMP).
- pc  output  PC_W  current PC, registered.
- sp  output  SP_W  number of valid stack entries, 0..DEPTH.
- empty  output  1  high when sp==0; combinational from sp.
- full  output  1  high when sp==DEPTH; combinational from sp.
- ovf  output  1  sticky flag: CALL was issued while full.
- unf  output  1  sticky flag: RET was issued while empty.

Behaviour:
- Reset values: pc=0, sp=0, ovf=0, unf=0, all stack entries 0.
- Reset has priority over stall and op.
- Arithmetic: all PC arithmetic is modulo 2^PC_W; the sum wraps with no carry out.
  - Let seq = pc+1.
  - Let tgt = pc+immd+1.
- Latency: one cycle. The command sampled at edge N is reflected on pc/sp at edge N; there is no combinational path from op to pc.
- stall=1: pc, sp, stack, ovf and unf all hold, regardless of op.
- NEXT: pc<=seq.
- BRC: pc<=tgt if flag=1, else pc<=seq.
- CALL, not full: stack[sp]<=seq, sp<=sp+1, pc<=tgt.
- CALL, full: no push, sp holds, pc<=seq, ovf<=1.
- RET, not empty: pc<=stack[sp-1], sp<=sp-1. The entry is not cleared.
- RET, empty: sp holds, pc<=seq, unf<=1.
- JMP: pc<=immd.
- HOLD (101/110/111): pc, sp and the stack are unchanged.
- ovf and unf stay set until rst; no other event clears them.
- Stack is LIFO.
  - Entry index sp-1 is the top of stack.
  - Back-to-back CALL/RET in consecutive cycles must use the sp updated by the previous edge; no bypass beyond that is required.
- A CALL whose target equals its own return address (immd = all-ones, so tgt=pc) is legal and is handled as a normal CALL.
- Reset mid-sequence (any state, any op) discards all stack contents and returns to reset values on the next edge.

Test Plan:
- Reset, then 3×NEXT -> pc 0,1,2,3; sp=0, empty=1, full=0, ovf=0, unf=0.
- At pc=0x010: BRC immd=0x005 flag=1 -> pc=0x016. Then BRC immd=0x005 flag=0 -> pc=0x017. At pc=0xFFE: BRC immd=0x001 flag=1 -> pc=0x000 (wrap).
- Nested calls:
  - At pc=0x020: CALL immd=0x0FF -> pc=0x120, sp=1.
  - Then CALL immd=0x00F -> pc=0x130, sp=2.
  - Then RET -> pc=0x121, sp=1.
  - Then RET -> pc=0x021, sp=0, empty=1.
- Overflow: 8 CALLs -> sp=8, full=1. 9th CALL at pc=P -> pc=P+1, sp=8, ovf=1. ovf stays 1 through subsequent RETs until rst.
- Underflow and hold:
  - RET with sp=0 at pc=0x040 -> pc=0x041, unf=1.
  - JMP immd=0xABC -> pc=0xABC.
  - op=111 -> pc stays 0xABC.
- Stall and reset:
  - stall=1 with CALL for 3 cycles -> pc, sp and flags unchanged.
  - rst=1 asserted with stall=1 and sp=3 -> pc=0, sp=0, ovf=0, unf=0 at the next edge.
